// File: rtl/insn_prefetch_pkg.sv
// -----------------------------------------------------------------------------
// insn_prefetch_pkg
//
// Shared constants for the instruction prefetch unit:
//   - fetch state machine encodings (PF_IDLE / PF_REQ / PF_DROP)
//   - instruction word width
// Imported by insn_prefetch and insn_fifo.
// -----------------------------------------------------------------------------
package insn_prefetch_pkg;

    // Width of one instruction word returned by memory.
    localparam int INSN_W = 32;

    // Fetch state machine encodings.
    //   PF_IDLE : no request outstanding (mem_req=0)
    //   PF_REQ  : request outstanding, returned word will be queued
    //   PF_DROP : request outstanding, returned word will be discarded
    //             because a redirect arrived after the request was issued
    localparam int          PF_STATE_W = 2;
    localparam logic [1:0]  PF_IDLE    = 2'b00;
    localparam logic [1:0]  PF_REQ     = 2'b01;
    localparam logic [1:0]  PF_DROP    = 2'b10;

endpackage : insn_prefetch_pkg

// File: rtl/insn_fifo.sv
// -----------------------------------------------------------------------------
// insn_fifo
//
// Synchronous FIFO holding {fetch address, instruction word} entries.
// Read data is taken combinationally from storage at the read pointer, so a
// word written at edge N is visible at the head right after edge N.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   flush_i        empty the FIFO at the next edge; wins over push and pop
//   push_i         write wdata_i (ignored when full unless a pop frees a slot)
//   wdata_i        entry to write
//   pop_i          remove the head entry (ignored when empty)
//   valid_o        FIFO non-empty
//   rdata_o        head entry, zero when empty
//   count_next_o   occupancy after this cycle's flush/push/pop
//
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module insn_fifo
    import insn_prefetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = INSN_W + 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic                     valid_o,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_next_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic empty;
    logic full;
    logic push_ok;
    logic pop_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // A push into a full FIFO is accepted when the head leaves in the same
    // cycle: the freed slot is the one being written.
    assign pop_ok  = pop_i && !empty;
    assign push_ok = push_i && (!full || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign valid_o      = !empty;
    assign rdata_o      = empty ? '0 : mem_q[rd_ptr_q];
    assign count_next_o = count_d;

endmodule : insn_fifo

// File: rtl/insn_prefetch.sv
// -----------------------------------------------------------------------------
// insn_prefetch
//
// Instruction prefetch unit. Fetches 32-bit words from a variable-latency
// instruction memory (one request outstanding at most), queues them with their
// fetch address and hands them to the core. A redirect flushes the queue and
// restarts fetch at redirect_pc.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   mem_req        request to instruction memory (registered)
//   mem_addr       word address of the request (registered, held until ack)
//   mem_ack        memory returns mem_rdata this cycle (only while mem_req=1)
//   mem_rdata      returned instruction word
//   insn_valid     head entry present
//   insn, insn_pc  head instruction word and its fetch address
//   insn_ready     core accepts the head
//   redirect       flush and restart fetch at redirect_pc
//   redirect_pc    new fetch address
//   dbg_state      current fetch state (PF_IDLE / PF_REQ / PF_DROP)
//
// Handshakes: the core side transfers the head on a rising edge where
// insn_valid && insn_ready; insn_valid never depends on insn_ready. The memory
// side completes a request on a rising edge where mem_req && mem_ack; mem_addr
// is stable from the edge that raises mem_req until that completing edge.
// -----------------------------------------------------------------------------
module insn_prefetch
    import insn_prefetch_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  mem_req,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic                  mem_ack,
    input  logic [INSN_W-1:0]     mem_rdata,
    output logic                  insn_valid,
    output logic [INSN_W-1:0]     insn,
    output logic [ADDR_W-1:0]     insn_pc,
    input  logic                  insn_ready,
    input  logic                  redirect,
    input  logic [ADDR_W-1:0]     redirect_pc,
    output logic [PF_STATE_W-1:0] dbg_state
);

    localparam int FW = ADDR_W + INSN_W;
    localparam int CW = $clog2(DEPTH) + 1;

    // fetch_pc_q is the address of the next request not yet issued.
    logic [PF_STATE_W-1:0] state_q,    state_d;
    logic [ADDR_W-1:0]     fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic                  mem_req_q,  mem_req_d;

    logic          push;
    logic          pop;
    logic          space;
    logic [FW-1:0] fifo_rdata;
    logic [CW-1:0] fifo_count_next;

    // A word is kept only when it returns in PF_REQ with no redirect in the
    // same cycle; a redirect discards it and flushes the queue instead.
    assign push = (state_q == PF_REQ) && mem_ack && !redirect;
    assign pop  = insn_valid && insn_ready;

    // Room for one more word once this cycle's flush/push/pop has settled.
    // Issuing only under this condition keeps an outstanding request's word
    // guaranteed a slot when it returns.
    assign space = (fifo_count_next < CW'(DEPTH));

    insn_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (redirect),
        .push_i       (push),
        .wdata_i      ({mem_addr_q, mem_rdata}),
        .pop_i        (pop),
        .valid_o      (insn_valid),
        .rdata_o      (fifo_rdata),
        .count_next_o (fifo_count_next)
    );

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            PF_IDLE: begin
                // A redirect flushes the queue, so space is always available.
                if (redirect) begin
                    state_d    = PF_REQ;
                    mem_addr_d = redirect_pc;
                    fetch_pc_d = redirect_pc + ADDR_W'(1);
                end else if (space) begin
                    state_d    = PF_REQ;
                    mem_addr_d = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                end
            end
            PF_REQ: begin
                if (mem_ack) begin
                    if (redirect) begin
                        mem_addr_d = redirect_pc;
                        fetch_pc_d = redirect_pc + ADDR_W'(1);
                    end else if (space) begin
                        mem_addr_d = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                    end else begin
                        state_d = PF_IDLE;
                    end
                end else if (redirect) begin
                    // The in-flight request cannot be recalled; its word is
                    // thrown away and fetch resumes at redirect_pc afterwards.
                    state_d    = PF_DROP;
                    fetch_pc_d = redirect_pc;
                end
            end
            PF_DROP: begin
                if (mem_ack) begin
                    state_d = PF_REQ;
                    if (redirect) begin
                        mem_addr_d = redirect_pc;
                        fetch_pc_d = redirect_pc + ADDR_W'(1);
                    end else begin
                        mem_addr_d = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                    end
                end else if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end
            end
            default: begin
                state_d = PF_IDLE;
            end
        endcase
    end

    assign mem_req_d = (state_d != PF_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PF_IDLE;
            fetch_pc_q <= RESET_PC;
            mem_addr_q <= '0;
            mem_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign insn      = fifo_rdata[INSN_W-1:0];
    assign insn_pc   = fifo_rdata[FW-1:INSN_W];
    assign dbg_state = state_q;

endmodule : insn_prefetch

// File: tb/tb_insn_prefetch.sv
// -----------------------------------------------------------------------------
// tb_insn_prefetch
//
// Bench for insn_prefetch (DEPTH=4, ADDR_W=8, RESET_PC=0). The memory image is
// a fixed function of the address. The stream model only knows that delivered
// addresses run consecutively from the last restart point (reset or redirect),
// that each word matches the image, and that a redirect empties the queue.
// -----------------------------------------------------------------------------
module tb_insn_prefetch;

  localparam int         DEPTH    = 4;
  localparam int         ADDR_W   = 8;
  localparam logic [7:0] RESET_PC = 8'h00;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        insn_valid;
  logic [31:0] insn;
  logic [7:0]  insn_pc;
  logic        insn_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic [1:0]  dbg_state;

  insn_prefetch #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .insn_valid(insn_valid), .insn(insn), .insn_pc(insn_pc), .insn_ready(insn_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [7:0] exp_pc = RESET_PC;
  logic [7:0] prev_addr = '0;
  logic       prev_req = 1'b0;
  logic       prev_ack = 1'b0;
  logic       flush_chk = 1'b0;
  int         acks = 0;
  int         delivered = 0;

  // memory responder state
  int   wait_cnt = 0;
  int   lat_fixed = 0;
  int   rnd_lat = 0;
  logic rand_lat = 1'b0;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {8'hC3, a, ~a, a ^ 8'h5A};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: acks after a per-request number of wait cycles.
  task automatic respond();
    int lat;
    lat = rand_lat ? rnd_lat : lat_fixed;
    if (!rst_n || !mem_req) begin
      mem_ack   = 1'b0;
      mem_rdata = 32'h0BAD0000;
      wait_cnt  = 0;
    end else if (wait_cnt >= lat) begin
      mem_ack   = 1'b1;
      mem_rdata = mem_word(mem_addr);
      wait_cnt  = 0;
      rnd_lat   = $urandom_range(0, 3);
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 32'h0BAD0000 | 32'(wait_cnt);
      wait_cnt++;
    end
  endtask

  // Stream model, evaluated with the inputs for the coming edge applied.
  task automatic monitor();
    if (!rst_n) begin
      exp_pc    = RESET_PC;
      prev_req  = 1'b0;
      prev_ack  = 1'b0;
      flush_chk = 1'b0;
      acks      = 0;
    end else begin
      if (flush_chk) check("flush_empty", 32'(insn_valid), 32'd0);
      if (prev_req && !prev_ack) begin
        check("req_hold", 32'(mem_req), 32'd1);
        check("addr_hold", 32'(mem_addr), 32'(prev_addr));
      end
      if (insn_valid && insn_ready) begin
        check("stream_pc", 32'(insn_pc), 32'(exp_pc));
        check("stream_data", insn, mem_word(exp_pc));
        exp_pc = exp_pc + 8'd1;
        delivered++;
      end
      if (redirect) exp_pc = redirect_pc;
      flush_chk = redirect;
      if (mem_req && mem_ack) acks++;
      prev_req  = mem_req;
      prev_ack  = mem_ack;
      prev_addr = mem_addr;
    end
  endtask

  // One clock: model sees current cycle, edge, then memory answers for the
  // new cycle. Returns 1 time unit after the rising edge.
  task automatic cycle();
    monitor();
    @(posedge clk);
    #1;
    respond();
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    redirect   = 1'b0;
    insn_ready = 1'b0;
    rand_lat   = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [7:0]  start;
    int          lat;
    logic [31:0] exp_pcs;   // first four delivered addresses, MSB byte first
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal;
  end

  initial begin
    int         n;
    int         d0;
    logic [7:0] got[4];
    logic [31:0] e;

    vecs[0] = '{8'hFE, 0, 32'hFEFF0001};
    vecs[1] = '{8'h40, 3, 32'h40414243};
    vecs[2] = '{8'h10, 1, 32'h10111213};
    vecs[3] = '{8'hFF, 2, 32'hFF000102};
    vecs[4] = '{8'h7E, 0, 32'h7E7F8081};

    // ---- reset values ----
    cycle();
    cycle();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_insn_valid", 32'(insn_valid), 32'd0);
    check("rst_insn", insn, 32'd0);
    check("rst_insn_pc", 32'(insn_pc), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // ---- first request and sustained one word per cycle ----
    insn_ready = 1'b1;
    lat_fixed  = 0;
    rst_n      = 1'b1;
    cycle();
    check("first_req", 32'(mem_req), 32'd1);
    check("first_addr", 32'(mem_addr), 32'(RESET_PC));
    cycle();
    for (int k = 0; k < 8; k++) begin
      check("seq_valid", 32'(insn_valid), 32'd1);
      check("seq_pc", 32'(insn_pc), 32'(k));
      check("seq_data", insn, mem_word(8'(k)));
      cycle();
    end

    // ---- back-pressure: fill exactly DEPTH words, then resume at 4 ----
    do_reset();
    lat_fixed = 0;
    repeat (12) cycle();
    check("bp_acks", 32'(acks), 32'(DEPTH));
    check("bp_req_low", 32'(mem_req), 32'd0);
    check("bp_head_pc", 32'(insn_pc), 32'd0);
    insn_ready = 1'b1;
    cycle();
    check("bp_resume_req", 32'(mem_req), 32'd1);
    check("bp_resume_addr", 32'(mem_addr), 32'd4);
    repeat (12) cycle();

    // ---- redirect while a slow request is pending ----
    do_reset();
    lat_fixed  = 3;
    insn_ready = 1'b1;
    n = 0;
    while (!(mem_req && mem_addr == 8'h05 && !mem_ack) && n < 100) begin
      cycle();
      n++;
    end
    check("drop_reach_05", 32'(n < 100), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 8'h40;
    cycle();
    redirect = 1'b0;
    check("drop_flush", 32'(insn_valid), 32'd0);
    n = 0;
    while (!mem_ack && n < 10) begin
      check("drop_addr_hold", 32'(mem_addr), 32'h05);
      cycle();
      n++;
    end
    check("drop_ack_seen", 32'(mem_ack), 32'd1);
    check("drop_ack_addr", 32'(mem_addr), 32'h05);
    cycle();
    check("drop_new_req", 32'(mem_req), 32'd1);
    check("drop_new_addr", 32'(mem_addr), 32'h40);
    n = 0;
    while (!insn_valid && n < 20) begin
      cycle();
      n++;
    end
    check("drop_first_valid", 32'(insn_valid), 32'd1);
    check("drop_first_pc", 32'(insn_pc), 32'h40);
    repeat (6) cycle();

    // ---- redirect coinciding with ack and pop on a loaded FIFO ----
    do_reset();
    lat_fixed = 0;
    n = 0;
    while (!(insn_valid && !mem_req) && n < 20) begin
      cycle();
      n++;
    end
    check("full_reached", 32'(n < 20), 32'd1);
    insn_ready = 1'b1;
    cycle();
    check("full_reissue_addr", 32'(mem_addr), 32'd4);
    check("full_ack_now", 32'(mem_ack), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 8'h10;
    cycle();
    redirect = 1'b0;
    check("coinc_valid", 32'(insn_valid), 32'd0);
    check("coinc_req", 32'(mem_req), 32'd1);
    check("coinc_addr", 32'(mem_addr), 32'h10);
    repeat (8) cycle();

    // ---- table: redirect targets incl. address wrap ----
    for (int i = 0; i < 5; i++) begin
      lat_fixed   = vecs[i].lat;
      insn_ready  = 1'b1;
      redirect    = 1'b1;
      redirect_pc = vecs[i].start;
      cycle();
      redirect = 1'b0;
      n = 0;
      for (int c = 0; c < 60 && n < 4; c++) begin
        if (insn_valid && insn_ready) begin
          got[n] = insn_pc;
          n++;
        end
        cycle();
      end
      check($sformatf("vec%0d_count", i), 32'(n), 32'd4);
      e = vecs[i].exp_pcs;
      for (int k = 0; k < n; k++) begin
        check($sformatf("vec%0d_pc%0d", i, k), 32'(got[k]), 32'(e[31-8*k -: 8]));
      end
    end

    // ---- reset asserted mid-request with two entries queued ----
    do_reset();
    lat_fixed = 2;
    n = 0;
    while (!(acks == 2 && mem_req && !mem_ack) && n < 30) begin
      cycle();
      n++;
    end
    check("mid_setup", 32'(n < 30), 32'd1);
    check("mid_valid_before", 32'(insn_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_req_low", 32'(mem_req), 32'd0);
    check("mid_valid_low", 32'(insn_valid), 32'd0);
    check("mid_addr_zero", 32'(mem_addr), 32'd0);
    check("mid_insn_zero", insn, 32'd0);
    cycle();
    rst_n = 1'b1;
    cycle();
    check("mid_restart_req", 32'(mem_req), 32'd1);
    check("mid_restart_addr", 32'(mem_addr), 32'(RESET_PC));
    insn_ready = 1'b1;
    repeat (10) cycle();

    // ---- randomized traffic against the stream model ----
    do_reset();
    rand_lat = 1'b1;
    d0 = delivered;
    for (int c = 0; c < 1500; c++) begin
      insn_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 99) < 4) begin
        redirect    = 1'b1;
        redirect_pc = 8'($urandom_range(0, 255));
      end else begin
        redirect = 1'b0;
      end
      cycle();
    end
    redirect = 1'b0;
    cycle();
    check("rand_progress", 32'((delivered - d0) > 200), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
